hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipelined ARMv8 core.
- Drives the Stall inputs of the stallable 64-bit pipeline registers (PC, IF/ID, ID/EX) and the bubble/flush controls of IF/ID, ID/EX and EX/MEM.
- Resolves three hazard sources: taken-branch redirects, load-use dependencies, and multi-cycle EX operations (MUL/DIV).

Parameters:
MULTI_LAT, 4, EX residency in cycles of a multi-cycle op; legal range 2..16; produces MULTI_LAT-1 stall cycles.
REG_W, 5, register specifier width; all-ones value (X31/XZR) never creates a hazard.

Ports:
clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous, active-low reset
id_rn  input  REG_W  ID-stage first source register
id_rm  input  REG_W  ID-stage second source register
id_use_rn  input  1  ID instruction reads id_rn
id_use_rm  input  1  ID instruction reads id_rm
ex_rd  input  REG_W  EX-stage destination register
ex_memread  input  1  EX instruction is a load (LDUR)
ex_mc  input  1  EX instruction is a multi-cycle op
br_taken  input  1  branch resolved taken this cycle (older instruction)
stall_pc  output  1  hold the PC register
stall_ifid  output  1  hold IF/ID
stall_idex  output  1  hold ID/EX
flush_ifid  output  1  load a bubble into IF/ID at the next edge
flush_idex  output  1  load a bubble into ID/EX at the next edge
flush_exmem  output  1  load a bubble into EX/MEM at the next edge
mc_busy  output  1  a multi-cycle sequence is in progress

Behaviour:
- Reset decided as: one clock (clk); Reset_n asynchronous, active-low.
- Reset_n=0 immediately forces state=RUN and cnt=0. All outputs read 0 while reset is asserted, including when reset is applied mid-sequence.
- FSM states: RUN, MC_BUSY, MC_DONE. cnt is a 4-bit down-counter.
- Outputs are combinational from the registered state and the current inputs. State and cnt update on the rising clk edge.
- Priority, highest first, evaluated in every state: br_taken > multi-cycle > load-use.
- br_taken=1 in any state:
  - flush_ifid=1 and flush_idex=1; all stalls=0; flush_exmem=0.
  - Next state RUN. An in-flight multi-cycle op is aborted, because the ID/EX flush kills it.
- Load-use hazard, lu:
  - lu = ex_memread & ex_rd!=all-ones & ((id_use_rn & id_rn==ex_rd) | (id_use_rm & id_rm==ex_rd)).
  - Evaluated in RUN and MC_DONE only.
  - Response: stall_pc=1, stall_ifid=1, flush_idex=1 for exactly that cycle. State is unchanged.
- RUN with ex_mc=1 (and no br_taken):
  - stall_pc=stall_ifid=stall_idex=1 and flush_exmem=1; mc_busy=1.
  - Next state MC_DONE if MULTI_LAT==2. Otherwise next state MC_BUSY with cnt<=MULTI_LAT-3.
- MC_BUSY:
  - Same stall and flush_exmem pattern; mc_busy=1.
  - If cnt==0, next state MC_DONE; otherwise cnt<=cnt-1.
- MC_DONE:
  - No stalls; mc_busy=0. ex_mc is ignored, so the completed op advances into MEM.
  - br_taken and lu are still evaluated. Next state RUN.
- Stall shape: a multi-cycle op yields exactly MULTI_LAT-1 consecutive stall cycles, then one release cycle.
- A new ex_mc presented in the cycle after MC_DONE starts a fresh sequence.
- All other RUN cycles: every output is 0.

Optional Feature:
- Macro HAZ_PERF_EN.
- When defined, adds outputs stall_cnt[31:0] and flush_cnt[31:0]:
  - stall_cnt increments on every cycle with stall_pc=1.
  - flush_cnt increments on every cycle with br_taken=1.
  - Both counters saturate at 32'hFFFFFFFF and clear to 0 on Reset_n=0.
- When not defined, the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Load-use: ex_memread=1, ex_rd=3, id_rn=3, id_use_rn=1 -> one cycle of stall_pc=stall_ifid=flush_idex=1; all outputs 0 the next cycle once ex_memread=0.
- XZR: same as above with ex_rd=id_rn=31 -> all outputs stay 0.
- Multi-cycle, MULTI_LAT=4: ex_mc=1 held -> stall_pc/ifid/idex, flush_exmem and mc_busy high for exactly 3 cycles (RUN, MC_BUSY x2); cycle 4 is MC_DONE with all 0; next cycle RUN.
- Branch abort: br_taken=1 in the second MC_BUSY cycle -> flush_ifid=flush_idex=1, stalls=0 that cycle; RUN next cycle with mc_busy=0.
- Priority: br_taken=1 with a simultaneous lu and ex_mc in RUN -> only flush_ifid=flush_idex=1; state stays RUN.
- Reset mid-operation: drop Reset_n in MC_BUSY -> outputs 0 immediately with no clock; after release, RUN with cnt=0. With HAZ_PERF_EN, after a 3-cycle multi-cycle sequence, stall_cnt=3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage pipelined ARMv8 core. It
// resolves three hazard sources, in this priority order:
//   1. taken-branch redirects
//   2. multi-cycle EX operations (MUL/DIV)
//   3. load-use dependencies
//
// Optional feature: define HAZ_PERF_EN to add the saturating performance
// counters stall_cnt and flush_cnt. Without the macro those ports and their
// logic are absent, and the rest of the behaviour is unchanged.
//
// Parameters:
//   MULTI_LAT  EX residency of a multi-cycle op, in cycles (2..16).
//              A multi-cycle op produces MULTI_LAT-1 stall cycles.
//   REG_W      register specifier width. The all-ones specifier (XZR)
//              never creates a hazard.
//
// Ports:
//   clk          rising-edge clock
//   Reset_n      asynchronous, active-low reset
//   id_rn/id_rm  ID-stage source registers
//   id_use_rn/rm ID instruction actually reads id_rn / id_rm
//   ex_rd        EX-stage destination register
//   ex_memread   EX instruction is a load
//   ex_mc        EX instruction is a multi-cycle op
//   br_taken     an older branch resolved taken this cycle
//   stall_*      hold the PC, IF/ID and ID/EX pipeline registers
//   flush_*      load a bubble into IF/ID, ID/EX and EX/MEM at the next edge
//   mc_busy      a multi-cycle sequence is in progress
//   stall_cnt    (HAZ_PERF_EN) number of cycles with stall_pc=1
//   flush_cnt    (HAZ_PERF_EN) number of cycles with br_taken=1
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MULTI_LAT = 4,
    parameter int REG_W     = 5
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memread,
    input  logic             ex_mc,
    input  logic             br_taken,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             mc_busy
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } state_t;

    // The RUN cycle is the first stall cycle and MC_DONE is the release
    // cycle. That leaves MULTI_LAT-2 MC_BUSY cycles, so the counter is
    // loaded with MULTI_LAT-3 and terminates on zero.
    localparam logic [3:0] LP_CNT_INIT = (MULTI_LAT > 2) ? 4'(MULTI_LAT - 3) : 4'd0;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_lu;

    // XZR reads as zero, so a load targeting it can never feed a consumer.
    assign w_lu = ex_memread && (ex_rd != '1) &&
                  ((id_use_rn && (id_rn == ex_rd)) ||
                   (id_use_rm && (id_rm == ex_rd)));

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        mc_busy     = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        if (!Reset_n) begin
            // Every output reads 0 while reset is held, even mid-sequence.
            w_state_nxt = RUN;
            w_cnt_nxt   = 4'd0;
        end else if (br_taken) begin
            // The ID/EX flush kills any in-flight multi-cycle op,
            // so the sequence is abandoned.
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (ex_mc) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        stall_idex  = 1'b1;
                        flush_exmem = 1'b1;
                        mc_busy     = 1'b1;
                        if (MULTI_LAT == 2) begin
                            w_state_nxt = MC_DONE;
                        end else begin
                            w_state_nxt = MC_BUSY;
                            w_cnt_nxt   = LP_CNT_INIT;
                        end
                    end else if (w_lu) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end
                end
                MC_BUSY: begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    stall_idex  = 1'b1;
                    flush_exmem = 1'b1;
                    mc_busy     = 1'b1;
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = MC_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                MC_DONE: begin
                    // ex_mc is ignored here so that the finished op
                    // advances into MEM.
                    w_state_nxt = RUN;
                    if (w_lu) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef HAZ_PERF_EN
    // Both counters saturate instead of wrapping, so that a long run still
    // reads as "at least" this many events.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall_pc && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (br_taken && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl with the default parameters
// (MULTI_LAT=4, REG_W=5). Inputs change on the falling edge, and outputs
// are compared 1 time unit later, well away from the rising edge.
// Expected outputs are packed as
//   {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem, mc_busy}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [6:0] EXP_IDLE  = 7'b000_00_0_0;
    localparam logic [6:0] EXP_LU    = 7'b110_01_0_0;
    localparam logic [6:0] EXP_MC    = 7'b111_00_1_1;
    localparam logic [6:0] EXP_BR    = 7'b000_11_0_0;

    logic       clk;
    logic       Reset_n;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_use_rn;
    logic       id_use_rm;
    logic [4:0] ex_rd;
    logic       ex_memread;
    logic       ex_mc;
    logic       br_taken;
    logic       stall_pc;
    logic       stall_ifid;
    logic       stall_idex;
    logic       flush_ifid;
    logic       flush_idex;
    logic       flush_exmem;
    logic       mc_busy;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int errors;
    int checks;

    typedef struct {
        logic [4:0] rn;
        logic [4:0] rm;
        logic       use_rn;
        logic       use_rm;
        logic [4:0] rd;
        logic       memread;
        logic       mc;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[10];

    hazard_ctrl #(
        .MULTI_LAT(4),
        .REG_W(5)
    ) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .id_rn      (id_rn),
        .id_rm      (id_rm),
        .id_use_rn  (id_use_rn),
        .id_use_rm  (id_use_rm),
        .ex_rd      (ex_rd),
        .ex_memread (ex_memread),
        .ex_mc      (ex_mc),
        .br_taken   (br_taken),
        .stall_pc   (stall_pc),
        .stall_ifid (stall_ifid),
        .stall_idex (stall_idex),
        .flush_ifid (flush_ifid),
        .flush_idex (flush_idex),
        .flush_exmem(flush_exmem),
        .mc_busy    (mc_busy)
`ifdef HAZ_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one cycle's inputs on the falling edge and then settles.
    task automatic applyStimulus(input logic [4:0] rn, input logic [4:0] rm,
                                 input logic use_rn, input logic use_rm,
                                 input logic [4:0] rd, input logic memread,
                                 input logic mc, input logic br);
        @(negedge clk);
        id_rn      = rn;
        id_rm      = rm;
        id_use_rn  = use_rn;
        id_use_rm  = use_rm;
        ex_rd      = rd;
        ex_memread = memread;
        ex_mc      = mc;
        br_taken   = br;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic applyMc(input logic br);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, br);
    endtask

    task automatic checkOutput(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex,
               flush_exmem, mc_busy};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic checkCount(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0] = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, EXP_IDLE};
        vecs[1] = '{5'd3,  5'd0, 1'b1, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, EXP_LU};
        vecs[2] = '{5'd1,  5'd7, 1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, EXP_LU};
        vecs[3] = '{5'd3,  5'd0, 1'b0, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, EXP_IDLE};
        vecs[4] = '{5'd31, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, EXP_IDLE};
        vecs[5] = '{5'd3,  5'd3, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, EXP_IDLE};
        vecs[6] = '{5'd3,  5'd5, 1'b1, 1'b1, 5'd4,  1'b1, 1'b0, 1'b0, EXP_IDLE};
        vecs[7] = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, EXP_BR};
        vecs[8] = '{5'd3,  5'd0, 1'b1, 1'b0, 5'd3,  1'b1, 1'b1, 1'b1, EXP_BR};
        vecs[9] = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, EXP_BR};

        // While reset is held, outputs stay 0 even with hazards presented.
        Reset_n    = 1'b0;
        id_rn      = 5'd3;
        id_rm      = 5'd0;
        id_use_rn  = 1'b1;
        id_use_rm  = 1'b0;
        ex_rd      = 5'd3;
        ex_memread = 1'b1;
        ex_mc      = 1'b1;
        br_taken   = 1'b1;
        #2;
        checkOutput("reset_outputs", EXP_IDLE);
        applyIdle();
        Reset_n = 1'b1;
        applyIdle();
        checkOutput("after_reset_idle", EXP_IDLE);

        // Single-cycle decisions made in RUN. None of these leave RUN.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rn, vecs[i].rm, vecs[i].use_rn, vecs[i].use_rm,
                          vecs[i].rd, vecs[i].memread, vecs[i].mc, vecs[i].br);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end
        // A branch that overrode ex_mc must have left the FSM in RUN.
        applyIdle();
        checkOutput("prio_stays_run", EXP_IDLE);

        // Load-use lasts exactly one cycle.
        applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_cycle", EXP_LU);
        applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_release", EXP_IDLE);

        // ex_mc held: 3 stall cycles, a release cycle, then back to RUN.
        for (int c = 0; c < 3; c++) begin
            applyMc(1'b0);
            checkOutput($sformatf("mc_stall%0d", c), EXP_MC);
        end
        applyMc(1'b0);
        checkOutput("mc_done", EXP_IDLE);
        applyIdle();
        checkOutput("mc_back_run", EXP_IDLE);

        // Load-use is still honoured in MC_DONE. A new ex_mc right after
        // the release cycle starts a fresh sequence.
        for (int c = 0; c < 3; c++) begin
            applyMc(1'b0);
            checkOutput($sformatf("mc2_stall%0d", c), EXP_MC);
        end
        applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        checkOutput("mc_done_lu", EXP_LU);
        applyMc(1'b0);
        checkOutput("mc_fresh_start", EXP_MC);
        applyMc(1'b0);
        applyMc(1'b0);
        applyIdle();
        checkOutput("mc_fresh_done", EXP_IDLE);

        // A branch in the second MC_BUSY cycle aborts the sequence.
        applyMc(1'b0);
        checkOutput("abort_run", EXP_MC);
        applyMc(1'b0);
        checkOutput("abort_busy1", EXP_MC);
        applyMc(1'b1);
        checkOutput("abort_branch", EXP_BR);
        applyIdle();
        checkOutput("abort_back_run", EXP_IDLE);

        // Reset dropped mid-sequence clears the outputs without a clock edge.
        applyMc(1'b0);
        checkOutput("rst_mid_run", EXP_MC);
        applyMc(1'b0);
        checkOutput("rst_mid_busy", EXP_MC);
        #1;
        Reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_async", EXP_IDLE);
        applyIdle();
        Reset_n = 1'b1;
        applyIdle();
        checkOutput("rst_mid_release", EXP_IDLE);
        for (int c = 0; c < 3; c++) begin
            applyMc(1'b0);
            checkOutput($sformatf("rst_mc_stall%0d", c), EXP_MC);
        end
        applyIdle();
        checkOutput("rst_mc_done", EXP_IDLE);
`ifdef HAZ_PERF_EN
        checkCount("stall_cnt", stall_cnt, 32'd3);
        checkCount("flush_cnt", flush_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
